// File: rtl/wb_csr_bank.sv
// Wishbone classic slave exposing a bank of CSRs: RW control words, a sticky
// W1C status word with interrupt enable, and programmable ack wait states.
module wb_csr_bank #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned WAIT_STATES  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              wb_adr_i,
  input  logic [DATA_WIDTH-1:0]              wb_dat_i,
  output logic [DATA_WIDTH-1:0]              wb_dat_o,
  input  logic                               wb_we_i,
  input  logic [SELECT_WIDTH-1:0]            wb_sel_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_cyc_i,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] ctrl_o,
  input  logic [DATA_WIDTH-1:0]              event_i,
  output logic                               irq_o
);

  localparam int unsigned LSB        = (SELECT_WIDTH > 1) ? $clog2(SELECT_WIDTH) : 0;
  localparam int unsigned NUM_CTRL   = NUM_REGS - 2;
  localparam int unsigned STATUS_IDX = NUM_REGS - 2;
  localparam int unsigned IRQ_EN_IDX = NUM_REGS - 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    we_q;
  logic [SELECT_WIDTH-1:0] sel_q;

  logic [DATA_WIDTH-1:0]   ctrl_q [NUM_CTRL];
  logic [DATA_WIDTH-1:0]   status_q;
  logic [DATA_WIDTH-1:0]   irq_en_q;

  logic                    req;
  logic                    finish;
  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic                    cur_we;
  logic [SELECT_WIDTH-1:0] cur_sel;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic                    cur_valid;
  logic [DATA_WIDTH-1:0]   lane_mask;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   clear_mask;
  logic [DATA_WIDTH-1:0]   status_next;

  always_comb begin
    req = wb_cyc_i & wb_stb_i;

    // With zero wait states the response edge is the sampling edge, so the
    // live bus is used; otherwise the request latched in IDLE is used.
    if (state == IDLE) begin
      cur_adr = wb_adr_i;
      cur_dat = wb_dat_i;
      cur_we  = wb_we_i;
      cur_sel = wb_sel_i;
    end else begin
      cur_adr = adr_q;
      cur_dat = dat_q;
      cur_we  = we_q;
      cur_sel = sel_q;
    end

    finish = 1'b0;
    case (state)
      IDLE:    finish = req && (WAIT_STATES == 0);
      WAIT:    finish = wb_cyc_i && (wait_cnt == 4'd1);
      default: finish = 1'b0;
    endcase

    cur_idx   = cur_adr >> LSB;
    cur_valid = cur_idx < ADDR_WIDTH'(NUM_REGS);

    lane_mask = '0;
    for (int unsigned b = 0; b < SELECT_WIDTH; b++) begin
      lane_mask[b*8 +: 8] = {8{cur_sel[b]}};
    end

    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (cur_idx == ADDR_WIDTH'(i)) rd_data = ctrl_q[i];
    end
    if (cur_idx == ADDR_WIDTH'(STATUS_IDX)) rd_data = status_q;
    if (cur_idx == ADDR_WIDTH'(IRQ_EN_IDX)) rd_data = irq_en_q;

    clear_mask = '0;
    if (finish && cur_we && (cur_idx == ADDR_WIDTH'(STATUS_IDX))) begin
      clear_mask = cur_dat & lane_mask;
    end
    // New events are ORed after the clear so a same-cycle event survives.
    status_next = (status_q & ~clear_mask) | event_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      irq_o    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      status_q <= status_next;
      irq_o    <= |(status_q & irq_en_q);

      case (state)
        IDLE: begin
          if (req) begin
            adr_q    <= wb_adr_i;
            dat_q    <= wb_dat_i;
            we_q     <= wb_we_i;
            sel_q    <= wb_sel_i;
            wait_cnt <= 4'(WAIT_STATES);
            state    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd1) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (finish) begin
        wb_ack_o <= cur_valid;
        wb_err_o <= !cur_valid;
        if (cur_valid && !cur_we) begin
          wb_dat_o <= rd_data;
        end
        if (cur_valid && cur_we) begin
          for (int unsigned i = 0; i < NUM_CTRL; i++) begin
            if (cur_idx == ADDR_WIDTH'(i)) begin
              ctrl_q[i] <= (ctrl_q[i] & ~lane_mask) | (cur_dat & lane_mask);
            end
          end
          if (cur_idx == ADDR_WIDTH'(IRQ_EN_IDX)) begin
            irq_en_q <= (irq_en_q & ~lane_mask) | (cur_dat & lane_mask);
          end
        end
      end
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      ctrl_o[i*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[i];
    end
  end

endmodule

// File: tb/tb_wb_csr_bank.sv
// Scoreboard bench for wb_csr_bank: two instances (1 and 3 wait states) share
// one master; responses are matched against a queue of expected results.
module tb_wb_csr_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned NR = 8;

  typedef struct {
    logic          tgt;
    logic          err;
    logic          chk;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          bus_tgt = 1'b0;
  logic [AW-1:0] adr     = '0;
  logic [DW-1:0] dat     = '0;
  logic          we      = 1'b0;
  logic [SW-1:0] sel     = '0;
  logic          cyc     = 1'b0;
  logic          stb     = 1'b0;
  logic [DW-1:0] event1  = '0;
  logic [DW-1:0] event3  = '0;

  logic cyc1, stb1, cyc3, stb3;
  assign cyc1 = cyc & ~bus_tgt;
  assign stb1 = stb & ~bus_tgt;
  assign cyc3 = cyc & bus_tgt;
  assign stb3 = stb & bus_tgt;

  logic [DW-1:0]        dat_o1, dat_o3;
  logic                 ack1, err1, ack3, err3, irq1, irq3;
  logic [(NR-2)*DW-1:0] ctrl1, ctrl3;

  wb_csr_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o1),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb1), .wb_cyc_i(cyc1),
    .wb_ack_o(ack1), .wb_err_o(err1), .ctrl_o(ctrl1), .event_i(event1), .irq_o(irq1)
  );

  wb_csr_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o3),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb3), .wb_cyc_i(cyc3),
    .wb_ack_o(ack3), .wb_err_o(err3), .ctrl_o(ctrl3), .event_i(event3), .irq_o(irq3)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        mon_en   = 1'b0;
  exp_t        sb[$];
  exp_t        mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One master transfer; evt (if nonzero) is pulsed in the cycle ending at the commit edge.
  task automatic wb_xfer(input logic tgt, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [SW-1:0] s, input logic exp_err,
                         input logic [DW-1:0] exp_dat, input logic [DW-1:0] evt);
    exp_t        e;
    int unsigned ws;
    int unsigned n;
    logic        done;
    ws = tgt ? 3 : 1;
    @(posedge clk); #1;
    bus_tgt = tgt; adr = a; dat = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    e.tgt = tgt;
    e.err = exp_err;
    e.chk = !w || exp_err;
    e.dat = exp_err ? '0 : exp_dat;
    sb.push_back(e);
    @(posedge clk);
    if (evt != '0) begin
      fork
        begin
          repeat (ws - 1) @(posedge clk);
          #1 event1 = evt;
          @(posedge clk);
          #1 event1 = '0;
        end
      join_none
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (tgt ? (ack3 | err3) : (ack1 | err1)) done = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check_eq("resp_timeout", done, 1'b1);
    check_eq("latency", n, ws);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("ack_err_excl", (ack1 & err1) | (ack3 & err3), 1'b0);
      if (!ack1) check_eq("dat_zero_idle", dat_o1, '0);
      if (ack1 | err1 | ack3 | err3) begin
        check_eq("sb_pending", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("sb_target", ack3 | err3, mon_e.tgt);
          check_eq("sb_err", mon_e.tgt ? err3 : err1, mon_e.err);
          check_eq("sb_ack", mon_e.tgt ? ack3 : ack1, !mon_e.err);
          if (mon_e.chk) check_eq("sb_rdata", mon_e.tgt ? dat_o3 : dat_o1, mon_e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bdat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_ack", ack1, 1'b0);
    check_eq("rst_err", err1, 1'b0);
    check_eq("rst_dat", dat_o1, '0);
    check_eq("rst_irq", irq1, 1'b0);
    check_eq("rst_ctrl_lo", ctrl1[63:0], '0);
    check_eq("rst_ctrl_hi", ctrl1[191:128], '0);

    // full-word write then readback
    wb_xfer(0, 32'h04, 32'hA5A5A5A5, 1, 4'hF, 0, '0, '0);
    check_eq("ctrl1_word", ctrl1[63:32], 32'hA5A5A5A5);
    wb_xfer(0, 32'h04, '0, 0, 4'hF, 0, 32'hA5A5A5A5, '0);

    // byte-lane merge
    wb_xfer(0, 32'h00, 32'hFFFFFFFF, 1, 4'hF, 0, '0, '0);
    wb_xfer(0, 32'h00, 32'h11223344, 1, 4'h5, 0, '0, '0);
    check_eq("ctrl0_lanes", ctrl1[31:0], 32'hFF22FF44);
    wb_xfer(0, 32'h00, '0, 0, 4'h0, 0, 32'hFF22FF44, '0);
    wb_xfer(0, 32'h07, '0, 0, 4'h1, 0, 32'hA5A5A5A5, '0);

    // invalid index and last valid index
    wb_xfer(0, 32'h20, '0, 0, 4'hF, 1, '0, '0);
    wb_xfer(0, 32'h20, 32'hFFFFFFFF, 1, 4'hF, 1, '0, '0);
    check_eq("inval_ctrl_lo", ctrl1[63:0], 64'hA5A5A5A5_FF22FF44);
    check_eq("inval_ctrl_hi", ctrl1[191:64], '0);
    wb_xfer(0, 32'h1C, '0, 0, 4'hF, 0, '0, '0);

    // status / interrupt
    wb_xfer(0, 32'h1C, 32'h1, 1, 4'hF, 0, '0, '0);
    @(posedge clk); #1 event1 = 32'h3;
    @(posedge clk); #1 event1 = '0;
    @(negedge clk);
    check_eq("irq_lag", irq1, 1'b0);
    @(negedge clk);
    check_eq("irq_set", irq1, 1'b1);
    wb_xfer(0, 32'h18, '0, 0, 4'hF, 0, 32'h3, '0);
    wb_xfer(0, 32'h18, 32'h1, 1, 4'hF, 0, '0, 32'h1);
    wb_xfer(0, 32'h18, '0, 0, 4'hF, 0, 32'h3, '0);
    wb_xfer(0, 32'h18, 32'h3, 1, 4'h2, 0, '0, '0);
    wb_xfer(0, 32'h18, '0, 0, 4'hF, 0, 32'h3, '0);
    check_eq("irq_still", irq1, 1'b1);
    wb_xfer(0, 32'h18, 32'h3, 1, 4'hF, 0, '0, '0);
    check_eq("irq_clear", irq1, 1'b0);
    wb_xfer(0, 32'h18, '0, 0, 4'hF, 0, '0, '0);

    // abort on the three-wait-state instance
    wb_xfer(1, 32'h00, 32'h12345678, 1, 4'hF, 0, '0, '0);
    @(posedge clk); #1;
    bus_tgt = 1'b1; adr = 32'h00; dat = 32'hDEADBEEF; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("abort_ctrl", ctrl3[31:0], 32'h12345678);
    wb_xfer(1, 32'h00, '0, 0, 4'hF, 0, 32'h12345678, '0);

    // reset during a pending write
    @(posedge clk); #1 event1 = 32'h1;
    @(posedge clk); #1 event1 = '0;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_irq", irq1, 1'b1);
    @(posedge clk); #1;
    bus_tgt = 1'b0; adr = 32'h08; dat = 32'h55; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check_eq("mrst_irq", irq1, 1'b0);
    check_eq("mrst_ctrl_lo", ctrl1[95:0], '0);
    check_eq("mrst_ctrl_hi", ctrl1[191:96], '0);
    check_eq("mrst_ctrl3", ctrl3[31:0], '0);
    wb_xfer(0, 32'h04, '0, 0, 4'hF, 0, '0, '0);
    wb_xfer(0, 32'h1C, '0, 0, 4'hF, 0, '0, '0);

    // byte-serial writes as the I2C bridge issues them
    for (int k = 0; k < 4; k++) begin
      bdat = 32'(8'h11 * (k + 1)) << (8 * k);
      wb_xfer(0, 32'h08 + 32'(k), bdat, 1, 4'(1 << k), 0, '0, '0);
    end
    check_eq("bridge_ctrl2", ctrl1[95:64], 32'h44332211);
    wb_xfer(0, 32'h08, '0, 0, 4'hF, 0, 32'h44332211, '0);

    repeat (5) @(posedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
